// File: rtl/rv32_exec_core.sv
// Multi-cycle RV32I integer core (ALU, LUI/AUIPC, JAL/JALR, branches, ebreak halt).
// Latency: 4 cycles per instruction (FETCH, WAIT, REGS, EXEC); imem read data one cycle after imem_en.
// Backpressure: none; the core stalls only in HALT, which it leaves on a resume pulse.
//
// Ports:
//   clk, resetn            single rising-edge clock, async active-low reset
//   imem_addr/en/rdata     synchronous instruction memory (word address, strobe, data)
//   resume                 pulse to leave HALT (pc advances past the ebreak)
//   pc, halted             current byte pc, HALT state indicator
//   retire, instret        per-instruction pulse and wrapping 32-bit retire count
//   illegal                sticky unsupported-opcode flag
//   dbg_sel, dbg_data      combinational register-bank debug read (x0 reads 0)
module rv32_exec_core #(
    parameter logic [31:0] RESET_PC   = 32'h0,
    parameter int          ADDR_WIDTH = 10
) (
    input  logic                  clk,
    input  logic                  resetn,
    output logic [ADDR_WIDTH-3:0] imem_addr,
    output logic                  imem_en,
    input  logic [31:0]           imem_rdata,
    input  logic                  resume,
    output logic [ADDR_WIDTH-1:0] pc,
    output logic                  halted,
    output logic                  retire,
    output logic [31:0]           instret,
    output logic                  illegal,
    input  logic [4:0]            dbg_sel,
    output logic [31:0]           dbg_data
);

    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_ALUIMM = 7'b0010011;
    localparam logic [6:0] OP_ALUREG = 7'b0110011;
    localparam logic [6:0] OP_SYSTEM = 7'b1110011;

    typedef enum logic [2:0] {
        FETCH_INSTR,
        WAIT_INSTR,
        FETCH_REGS,
        EXECUTE,
        HALT
    } state_t;

    state_t                state_q, state_d;
    logic [ADDR_WIDTH-1:0] pc_q, pc_d;
    logic [31:0]           instr_q, instr_d;
    logic [31:0]           rs1_q, rs1_d;
    logic [31:0]           rs2_q, rs2_d;
    logic [31:0]           instret_q, instret_d;
    logic                  retire_q, retire_d;
    logic                  illegal_q, illegal_d;

    // Register bank: deliberately not reset; x0 is never written.
    logic [31:0]           rf_q [32];
    logic                  rf_we;
    logic [4:0]            rf_waddr;
    logic [31:0]           rf_wdata;

    // ------------------------------------------------------------------
    // Decode
    // ------------------------------------------------------------------
    logic [6:0]  opcode;
    logic [4:0]  rd;
    logic [2:0]  funct3;
    logic        alt;          // funct7[5]: SUB / SRA select
    logic [31:0] imm_i, imm_u, imm_b, imm_j;
    logic [31:0] pc_ext, link;
    logic        is_alureg, is_ebreak;

    assign opcode    = instr_q[6:0];
    assign rd        = instr_q[11:7];
    assign funct3    = instr_q[14:12];
    assign alt       = instr_q[30];
    assign imm_i     = {{20{instr_q[31]}}, instr_q[31:20]};
    assign imm_u     = {instr_q[31:12], 12'b0};
    assign imm_b     = {{20{instr_q[31]}}, instr_q[7], instr_q[30:25], instr_q[11:8], 1'b0};
    assign imm_j     = {{12{instr_q[31]}}, instr_q[19:12], instr_q[20], instr_q[30:21], 1'b0};
    assign pc_ext    = 32'(pc_q);
    assign link      = pc_ext + 32'd4;
    assign is_alureg = (opcode == OP_ALUREG);
    assign is_ebreak = (opcode == OP_SYSTEM) && instr_q[20];

    // ------------------------------------------------------------------
    // ALU
    // ------------------------------------------------------------------
    logic [31:0] alu_b;
    logic [4:0]  shamt;
    logic [31:0] alu_res;

    assign alu_b = is_alureg ? rs2_q : imm_i;
    assign shamt = alu_b[4:0];

    always_comb begin
        alu_res = 32'd0;
        case (funct3)
            3'b000:  alu_res = (is_alureg && alt) ? (rs1_q - alu_b) : (rs1_q + alu_b);
            3'b001:  alu_res = rs1_q << shamt;
            3'b010:  alu_res = {31'd0, $signed(rs1_q) < $signed(alu_b)};
            3'b011:  alu_res = {31'd0, rs1_q < alu_b};
            3'b100:  alu_res = rs1_q ^ alu_b;
            3'b101:  alu_res = alt ? 32'($signed(rs1_q) >>> shamt) : (rs1_q >> shamt);
            3'b110:  alu_res = rs1_q | alu_b;
            default: alu_res = rs1_q & alu_b;
        endcase
    end

    // ------------------------------------------------------------------
    // Branch condition
    // ------------------------------------------------------------------
    logic take;

    always_comb begin
        take = 1'b0;
        case (funct3)
            3'b000:  take = (rs1_q == rs2_q);
            3'b001:  take = (rs1_q != rs2_q);
            3'b100:  take = ($signed(rs1_q) <  $signed(rs2_q));
            3'b101:  take = ($signed(rs1_q) >= $signed(rs2_q));
            3'b110:  take = (rs1_q <  rs2_q);
            3'b111:  take = (rs1_q >= rs2_q);
            default: take = 1'b0;  // 010/011 are not branches: fall through
        endcase
    end

    // ------------------------------------------------------------------
    // Write-back value and next pc for the instruction in EXECUTE.
    // Targets are truncated to the pc width, so pc wraps naturally.
    // ------------------------------------------------------------------
    logic                  wb_en;
    logic [31:0]           wb_val;
    logic [ADDR_WIDTH-1:0] next_pc;
    logic                  is_illegal;

    always_comb begin
        wb_en      = 1'b0;
        wb_val     = alu_res;
        next_pc    = ADDR_WIDTH'(link);
        is_illegal = 1'b0;
        case (opcode)
            OP_ALUREG, OP_ALUIMM: wb_en = 1'b1;
            OP_LUI: begin
                wb_en  = 1'b1;
                wb_val = imm_u;
            end
            OP_AUIPC: begin
                wb_en  = 1'b1;
                wb_val = pc_ext + imm_u;
            end
            OP_JAL: begin
                wb_en   = 1'b1;
                wb_val  = link;
                next_pc = ADDR_WIDTH'(pc_ext + imm_j);
            end
            OP_JALR: begin
                wb_en   = 1'b1;
                wb_val  = link;
                next_pc = ADDR_WIDTH'(rs1_q + imm_i);
            end
            OP_BRANCH: begin
                if (take) begin
                    next_pc = ADDR_WIDTH'(pc_ext + imm_b);
                end
            end
            OP_SYSTEM: ;  // ebreak handled by the FSM, everything else is a NOP
            default: is_illegal = 1'b1;
        endcase
    end

    // ------------------------------------------------------------------
    // Control FSM
    // ------------------------------------------------------------------
    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        instr_d   = instr_q;
        rs1_d     = rs1_q;
        rs2_d     = rs2_q;
        instret_d = instret_q;
        retire_d  = 1'b0;
        illegal_d = illegal_q;
        rf_we     = 1'b0;
        rf_waddr  = rd;
        rf_wdata  = wb_val;
        case (state_q)
            FETCH_INSTR: state_d = WAIT_INSTR;
            WAIT_INSTR: begin
                instr_d = imem_rdata;
                state_d = FETCH_REGS;
            end
            FETCH_REGS: begin
                rs1_d   = (instr_q[19:15] == 5'd0) ? 32'd0 : rf_q[instr_q[19:15]];
                rs2_d   = (instr_q[24:20] == 5'd0) ? 32'd0 : rf_q[instr_q[24:20]];
                state_d = EXECUTE;
            end
            EXECUTE: begin
                if (is_ebreak) begin
                    // pc stays on the ebreak; resume steps past it
                    state_d = HALT;
                end else begin
                    state_d   = FETCH_INSTR;
                    pc_d      = next_pc & ~ADDR_WIDTH'(3);
                    retire_d  = 1'b1;
                    instret_d = instret_q + 32'd1;
                    illegal_d = illegal_q | is_illegal;
                    rf_we     = wb_en && (rd != 5'd0);
                end
            end
            HALT: begin
                if (resume) begin
                    pc_d    = pc_q + ADDR_WIDTH'(4);
                    state_d = FETCH_INSTR;
                end
            end
            default: state_d = FETCH_INSTR;
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q   <= FETCH_INSTR;
            pc_q      <= RESET_PC[ADDR_WIDTH-1:0];
            instr_q   <= 32'd0;
            rs1_q     <= 32'd0;
            rs2_q     <= 32'd0;
            instret_q <= 32'd0;
            retire_q  <= 1'b0;
            illegal_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            instr_q   <= instr_d;
            rs1_q     <= rs1_d;
            rs2_q     <= rs2_d;
            instret_q <= instret_d;
            retire_q  <= retire_d;
            illegal_q <= illegal_d;
        end
    end

    // Write enable is derived from state_q, which reset forces out of
    // EXECUTE asynchronously, so an aborted instruction never writes back.
    always_ff @(posedge clk) begin
        if (rf_we) begin
            rf_q[rf_waddr] <= rf_wdata;
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    // Fetch strobe is held low while reset is asserted even though the
    // reset state is FETCH_INSTR.
    assign imem_en   = (state_q == FETCH_INSTR) && resetn;
    assign imem_addr = pc_q[ADDR_WIDTH-1:2];
    assign pc        = pc_q;
    assign halted    = (state_q == HALT);
    assign retire    = retire_q;
    assign instret   = instret_q;
    assign illegal   = illegal_q;
    assign dbg_data  = (dbg_sel == 5'd0) ? 32'd0 : rf_q[dbg_sel];

endmodule

// File: tb/tb_rv32_exec_core.sv
// Bench for rv32_exec_core: directed programs plus random ALU/branch programs,
// compared per retired instruction against an instruction-level model.
module tb_rv32_exec_core;

    localparam logic [31:0] EBREAK    = 32'h00100073;
    localparam logic [31:0] NOP       = 32'h00000013;
    localparam logic [6:0]  OP_LUI    = 7'b0110111;
    localparam logic [6:0]  OP_AUIPC  = 7'b0010111;
    localparam logic [6:0]  OP_JAL    = 7'b1101111;
    localparam logic [6:0]  OP_JALR   = 7'b1100111;
    localparam logic [6:0]  OP_BRANCH = 7'b1100011;
    localparam logic [6:0]  OP_ALUI   = 7'b0010011;
    localparam logic [6:0]  OP_ALUR   = 7'b0110011;
    localparam logic [6:0]  OP_SYSTEM = 7'b1110011;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // main core (ADDR_WIDTH 10)
    logic        resetn, imem_en, resume, halted, retire, illegal;
    logic [7:0]  imem_addr;
    logic [31:0] imem_rdata, instret, dbg_data;
    logic [9:0]  pc;
    logic [4:0]  dbg_sel;
    logic [31:0] mem [256];

    // small core for pc wrap (ADDR_WIDTH 6, reset pc 0x3C)
    logic        resetn_w, imem_en_w, resume_w, halted_w, retire_w, illegal_w;
    logic [3:0]  imem_addr_w;
    logic [31:0] imem_rdata_w, instret_w, dbg_data_w;
    logic [5:0]  pc_w;
    logic [4:0]  dbg_sel_w;
    logic [31:0] memw [16];

    rv32_exec_core #(.RESET_PC(32'h0), .ADDR_WIDTH(10)) dut (
        .clk(clk), .resetn(resetn), .imem_addr(imem_addr), .imem_en(imem_en),
        .imem_rdata(imem_rdata), .resume(resume), .pc(pc), .halted(halted),
        .retire(retire), .instret(instret), .illegal(illegal),
        .dbg_sel(dbg_sel), .dbg_data(dbg_data)
    );

    rv32_exec_core #(.RESET_PC(32'h3C), .ADDR_WIDTH(6)) dut_w (
        .clk(clk), .resetn(resetn_w), .imem_addr(imem_addr_w), .imem_en(imem_en_w),
        .imem_rdata(imem_rdata_w), .resume(resume_w), .pc(pc_w), .halted(halted_w),
        .retire(retire_w), .instret(instret_w), .illegal(illegal_w),
        .dbg_sel(dbg_sel_w), .dbg_data(dbg_data_w)
    );

    always @(posedge clk) if (imem_en)   imem_rdata   <= mem[imem_addr];
    always @(posedge clk) if (imem_en_w) imem_rdata_w <= memw[imem_addr_w];

    int n_vec = 0;
    int n_err = 0;

    // architectural model
    logic [31:0] m_x [32];
    bit          m_v [32];
    logic [31:0] m_pc, m_instret;
    bit          m_illegal;

    function automatic logic [31:0] enc_i(logic [6:0] op, logic [4:0] rd, logic [2:0] f3,
                                          logic [4:0] rs1, logic [11:0] imm);
        return {imm, rs1, f3, rd, op};
    endfunction
    function automatic logic [31:0] addi(logic [4:0] rd, logic [4:0] rs1, logic [11:0] imm);
        return enc_i(OP_ALUI, rd, 3'b000, rs1, imm);
    endfunction
    function automatic logic [31:0] enc_r(logic f7b5, logic [2:0] f3, logic [4:0] rd,
                                          logic [4:0] rs1, logic [4:0] rs2);
        return {1'b0, f7b5, 5'b0, rs2, rs1, f3, rd, OP_ALUR};
    endfunction
    function automatic logic [31:0] enc_u(logic [6:0] op, logic [4:0] rd, logic [19:0] imm);
        return {imm, rd, op};
    endfunction
    function automatic logic [31:0] enc_b(logic [2:0] f3, logic [4:0] rs1, logic [4:0] rs2,
                                          logic [12:0] off);
        return {off[12], off[10:5], rs2, rs1, f3, off[4:1], off[11], OP_BRANCH};
    endfunction
    function automatic logic [31:0] enc_j(logic [4:0] rd, logic [20:0] off);
        return {off[20], off[10:1], off[11], off[19:12], rd, OP_JAL};
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic clear_mem();
        for (int i = 0; i < 256; i++) mem[i] = EBREAK;
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, ":imem_en"}, {31'd0, imem_en}, 32'd0);
        check({tag, ":pc"},      32'(pc), 32'd0);
        check({tag, ":halted"},  {31'd0, halted}, 32'd0);
        check({tag, ":retire"},  {31'd0, retire}, 32'd0);
        check({tag, ":instret"}, instret, 32'd0);
        check({tag, ":illegal"}, {31'd0, illegal}, 32'd0);
    endtask

    task automatic do_reset(input string tag);
        @(negedge clk);
        resetn = 1'b0;
        resume = 1'b0;
        repeat (2) @(negedge clk);
        #1 check_reset_vals({tag, ":rst"});
        m_pc      = 32'd0;
        m_instret = 32'd0;
        m_illegal = 1'b0;
        @(negedge clk);
        resetn = 1'b1;
        #1 check({tag, ":first_fetch"}, {31'd0, imem_en}, 32'd1);
    endtask

    // Executes the instruction at m_pc on the model: ISA semantics in plain arithmetic.
    task automatic model_step();
        logic [31:0] in, a, b, y, ii, res, nxt, boff, joff;
        logic [4:0]  rd;
        logic [2:0]  f3;
        bit          wr, tk;
        int unsigned sh;
        in   = mem[m_pc[9:2]];
        rd   = in[11:7];
        f3   = in[14:12];
        a    = m_x[in[19:15]];
        b    = m_x[in[24:20]];
        ii   = {{20{in[31]}}, in[31:20]};
        boff = {{19{in[31]}}, in[31], in[7], in[30:25], in[11:8], 1'b0};
        joff = {{11{in[31]}}, in[31], in[19:12], in[20], in[30:21], 1'b0};
        nxt  = m_pc + 32'd4;
        wr   = 1'b0;
        tk   = 1'b0;
        res  = 32'd0;
        case (in[6:0])
            OP_ALUR, OP_ALUI: begin
                y  = (in[6:0] == OP_ALUR) ? b : ii;
                sh = int'(y % 32);
                wr = 1'b1;
                case (f3)
                    3'd0: res = (in[6:0] == OP_ALUR && in[30]) ? a - y : a + y;
                    3'd1: res = a << sh;
                    3'd2: res = (int'(a) < int'(y)) ? 32'd1 : 32'd0;
                    3'd3: res = (a < y) ? 32'd1 : 32'd0;
                    3'd4: res = a ^ y;
                    3'd5: res = in[30] ? 32'(int'(a) >>> sh) : a >> sh;
                    3'd6: res = a | y;
                    default: res = a & y;
                endcase
            end
            OP_LUI:   begin wr = 1'b1; res = {in[31:12], 12'd0}; end
            OP_AUIPC: begin wr = 1'b1; res = m_pc + {in[31:12], 12'd0}; end
            OP_JAL:   begin wr = 1'b1; res = m_pc + 32'd4; nxt = m_pc + joff; end
            OP_JALR:  begin wr = 1'b1; res = m_pc + 32'd4; nxt = a + ii; end
            OP_BRANCH: begin
                case (f3)
                    3'd0: tk = (a == b);
                    3'd1: tk = (a != b);
                    3'd4: tk = (int'(a) <  int'(b));
                    3'd5: tk = (int'(a) >= int'(b));
                    3'd6: tk = (a <  b);
                    3'd7: tk = (a >= b);
                    default: tk = 1'b0;
                endcase
                if (tk) nxt = m_pc + boff;
            end
            OP_SYSTEM: ;
            default: m_illegal = 1'b1;
        endcase
        if (wr && rd != 5'd0) begin
            m_x[rd] = res;
            m_v[rd] = 1'b1;
        end
        m_pc      = nxt & 32'h3FC;
        m_instret = m_instret + 32'd1;
    endtask

    task automatic run_prog(input string tag, input int budget, output int cycles);
        bit done;
        done   = 1'b0;
        cycles = 0;
        while (!done && cycles < budget) begin
            @(negedge clk);
            cycles++;
            if (retire === 1'b1) begin
                model_step();
                check($sformatf("%s:pc@%0d", tag, m_instret), 32'(pc), m_pc);
                check($sformatf("%s:instret@%0d", tag, m_instret), instret, m_instret);
                check($sformatf("%s:illegal@%0d", tag, m_instret), {31'd0, illegal}, {31'd0, m_illegal});
            end
            if (halted === 1'b1) done = 1'b1;
        end
        check({tag, ":halted"}, {31'd0, halted}, 32'd1);
        check({tag, ":halt_pc"}, 32'(pc), m_pc);
        check({tag, ":halt_instret"}, instret, m_instret);
    endtask

    task automatic rd_dbg(input logic [4:0] r, output logic [31:0] v);
        dbg_sel = r;
        #1 v = dbg_data;
    endtask

    task automatic check_regs(input string tag);
        logic [31:0] v;
        for (int r = 0; r < 32; r++) begin
            if (m_v[r]) begin
                rd_dbg(5'(r), v);
                check($sformatf("%s:x%0d", tag, r), v, m_x[r]);
            end
        end
    endtask

    task automatic gen_rand(output logic [31:0] w);
        int          k;
        logic [4:0]  rd, rs1, rs2;
        logic [2:0]  f3;
        logic [11:0] imm;
        logic        b;
        k   = int'($urandom_range(0, 6));
        rd  = 5'($urandom);
        rs1 = 5'($urandom);
        rs2 = 5'($urandom);
        f3  = 3'($urandom);
        imm = 12'($urandom);
        b   = 1'($urandom);
        case (k)
            0: w = enc_r((f3 == 3'd0 || f3 == 3'd5) ? b : 1'b0, f3, rd, rs1, rs2);
            1: begin
                if (f3 == 3'd1)      imm = {7'd0, imm[4:0]};
                else if (f3 == 3'd5) imm = {1'b0, b, 5'd0, imm[4:0]};
                w = enc_i(OP_ALUI, rd, f3, rs1, imm);
            end
            2: w = enc_u(OP_LUI, rd, 20'($urandom));
            3: w = enc_u(OP_AUIPC, rd, 20'($urandom));
            4: w = enc_b(f3, rs1, rs2, 13'd8);
            5: w = enc_j(rd, 21'd8);
            default: w = 32'h00000073;  // ecall: executes as NOP
        endcase
    endtask

    initial begin : watchdog
        #3000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin : main
        logic [31:0] v;
        int          cyc;
        int          idx;

        resetn = 1'b0; resume = 1'b0; dbg_sel = 5'd0;
        resetn_w = 1'b0; resume_w = 1'b0; dbg_sel_w = 5'd0;
        for (int r = 0; r < 32; r++) begin m_x[r] = 32'd0; m_v[r] = 1'b0; end
        m_v[0] = 1'b1;
        for (int i = 0; i < 16; i++) memw[i] = EBREAK;

        // ---- addi/addi/ebreak, halt timing ----
        clear_mem();
        mem[0] = addi(5'd1, 5'd0, 12'd5);
        mem[1] = addi(5'd1, 5'd1, 12'hFFD);
        mem[2] = EBREAK;
        do_reset("t1");
        run_prog("t1", 200, cyc);
        check("t1:halt_cycle", 32'(cyc), 32'd12);
        rd_dbg(5'd1, v);  check("t1:x1", v, 32'd2);
        check("t1:instret", instret, 32'd2);
        check("t1:pc", 32'(pc), 32'd8);
        check("t1:retire_low", {31'd0, retire}, 32'd0);

        // ---- shifts / compares / sub / x0 write ----
        clear_mem();
        mem[0] = addi(5'd1, 5'd0, 12'hFF8);
        mem[1] = addi(5'd2, 5'd0, 12'd2);
        mem[2] = enc_r(1'b1, 3'b101, 5'd3, 5'd1, 5'd2);
        mem[3] = enc_r(1'b0, 3'b101, 5'd4, 5'd1, 5'd2);
        mem[4] = enc_r(1'b0, 3'b010, 5'd5, 5'd1, 5'd2);
        mem[5] = enc_r(1'b0, 3'b011, 5'd6, 5'd1, 5'd2);
        mem[6] = enc_r(1'b1, 3'b000, 5'd7, 5'd1, 5'd2);
        mem[7] = addi(5'd0, 5'd0, 12'd7);
        do_reset("t2");
        run_prog("t2", 400, cyc);
        check_regs("t2");
        rd_dbg(5'd3, v); check("t2:sra", v, 32'hFFFFFFFE);
        rd_dbg(5'd4, v); check("t2:srl", v, 32'h3FFFFFFE);
        rd_dbg(5'd5, v); check("t2:slt", v, 32'd1);
        rd_dbg(5'd6, v); check("t2:sltu", v, 32'd0);
        rd_dbg(5'd7, v); check("t2:sub", v, 32'hFFFFFFF6);
        rd_dbg(5'd0, v); check("t2:x0", v, 32'd0);

        // ---- bne loop; resume outside HALT must be ignored ----
        clear_mem();
        mem[0] = addi(5'd1, 5'd0, 12'd0);
        do_reset("t3a");
        run_prog("t3a", 100, cyc);
        clear_mem();
        mem[0] = addi(5'd5, 5'd0, 12'd3);
        mem[1] = addi(5'd1, 5'd1, 12'd1);
        mem[2] = enc_b(3'b001, 5'd1, 5'd5, 13'h1FFC);
        do_reset("t3");
        @(negedge clk); resume = 1'b1;
        @(negedge clk); resume = 1'b0;
        run_prog("t3", 400, cyc);
        rd_dbg(5'd1, v); check("t3:x1", v, 32'd3);
        check("t3:instret", instret, 32'd7);
        check("t3:pc", 32'(pc), 32'd12);

        // ---- jal / jalr / lui / auipc ----
        clear_mem();
        for (int i = 0; i < 4; i++) mem[i] = NOP;
        mem[4]  = enc_j(5'd1, 21'd8);
        mem[5]  = enc_j(5'd0, 21'd12);
        mem[6]  = enc_i(OP_JALR, 5'd0, 3'b000, 5'd1, 12'd0);
        mem[8]  = enc_u(OP_AUIPC, 5'd3, 20'h00001);
        mem[9]  = enc_u(OP_LUI, 5'd2, 20'h12345);
        do_reset("t4");
        run_prog("t4", 400, cyc);
        check_regs("t4");
        rd_dbg(5'd1, v); check("t4:jal_link", v, 32'h14);
        rd_dbg(5'd2, v); check("t4:lui", v, 32'h12345000);
        rd_dbg(5'd3, v); check("t4:auipc", v, 32'h1020);
        check("t4:instret", instret, 32'd9);
        check("t4:pc", 32'(pc), 32'h28);

        // ---- illegal load, then ebreak and resume ----
        clear_mem();
        mem[0] = enc_i(7'b0000011, 5'd3, 3'b010, 5'd0, 12'd0);
        do_reset("t5");
        run_prog("t5", 200, cyc);
        check("t5:illegal", {31'd0, illegal}, 32'd1);
        rd_dbg(5'd3, v); check("t5:x3_kept", v, 32'h1020);
        check("t5:pc", 32'(pc), 32'd4);
        check("t5:instret", instret, 32'd1);
        @(negedge clk); resume = 1'b1;
        @(negedge clk); resume = 1'b0;
        m_pc = m_pc + 32'd4;
        #1;
        check("t5:resume_halted", {31'd0, halted}, 32'd0);
        check("t5:resume_pc", 32'(pc), 32'd8);
        check("t5:resume_fetch", {31'd0, imem_en}, 32'd1);
        run_prog("t5b", 200, cyc);
        check("t5b:illegal_sticky", {31'd0, illegal}, 32'd1);

        // ---- random programs ----
        for (int round = 0; round < 3; round++) begin
            clear_mem();
            idx = 0;
            for (int r = 1; r < 32; r++) begin
                mem[idx] = addi(5'(r), 5'd0, 12'($urandom));
                idx++;
            end
            for (int k = 0; k < 70; k++) begin
                gen_rand(v);
                mem[idx] = v;
                idx++;
            end
            do_reset($sformatf("rnd%0d", round));
            run_prog($sformatf("rnd%0d", round), 3000, cyc);
            check_regs($sformatf("rnd%0d", round));
        end

        // ---- pc wrap on the 6-bit core ----
        memw[15] = addi(5'd1, 5'd0, 12'd9);
        @(negedge clk);
        #1 check("wrap:reset_pc", 32'(pc_w), 32'h3C);
        @(negedge clk); resetn_w = 1'b1;
        cyc = 0;
        while (halted_w !== 1'b1 && cyc < 100) begin
            @(negedge clk);
            cyc++;
        end
        check("wrap:halted", {31'd0, halted_w}, 32'd1);
        check("wrap:pc", 32'(pc_w), 32'd0);
        check("wrap:instret", instret_w, 32'd1);
        dbg_sel_w = 5'd1;
        #1 check("wrap:x1", dbg_data_w, 32'd9);

        // ---- reset during EXECUTE of addi x1 ----
        clear_mem();
        mem[0] = 32'h0000000F;              // fence: counted as illegal
        mem[1] = addi(5'd1, 5'd1, 12'd1);
        do_reset("t8");
        repeat (7) @(negedge clk);
        check("t8:pre_illegal", {31'd0, illegal}, 32'd1);
        check("t8:pre_instret", instret, 32'd1);
        check("t8:pre_pc", 32'(pc), 32'd4);
        resetn = 1'b0;
        #1 check_reset_vals("t8:abort");
        repeat (2) @(negedge clk);
        rd_dbg(5'd1, v); check("t8:x1_kept", v, m_x[1]);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
